uart_tx_fifo: RTL and testbench

Parametrised successor to the single-byte UART transmitter. It buffers outgoing bytes in an internal FIFO and sends them back-to-back. Bit period, data width, parity and stop-bit count are all configurable at run time. It sits behind the APB UART register block, which drives the write port and the cfg_* fields.

---
 rtl/uart_tx_fifo.sv | 212 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal TX FIFO; frames go out back-to-back with
// run-time divisor, data width, parity and stop-bit count.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_data_bits,
    input  logic             cfg_parity_en,
    input  logic             cfg_parity_odd,
    input  logic             cfg_stop2,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] fifo_count,
    output logic             fifo_empty,
    output logic             fifo_full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CLK_FREQ <= 0) begin : g_param_check
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2 and CLK_FREQ > 0");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    state_t           state;
    logic [DIV_W-1:0] div_r, baud_cnt;
    logic [1:0]       dbits_r;
    logic             par_en_r, stop2_r, par_bit_r;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;

    logic             push, start_frame, bit_end, last_data, frame_end, done_next;
    logic [7:0]       head_m, data_mask;

    assign fifo_count = count;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign wr_ready   = !fifo_full;

    assign push      = wr_valid && !fifo_full;
    assign bit_end   = (baud_cnt == div_r - DIV_W'(1));
    // bit_idx counts data bits in DATA and stop bits in STOP
    assign last_data = (bit_idx == {1'b1, cfg_bits_unused_guard(dbits_r)});
    assign frame_end = (state == STOP) && bit_end && (!stop2_r || bit_idx[0]);
    assign start_frame = !fifo_empty && ((state == IDLE) || frame_end);

    function automatic logic [1:0] cfg_bits_unused_guard(input logic [1:0] b);
        return b;
    endfunction

    always_comb begin
        data_mask = 8'hFF;
        case (cfg_data_bits)
            2'b00:   data_mask = 8'h1F;
            2'b01:   data_mask = 8'h3F;
            2'b10:   data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
        head_m = mem[rd_ptr] & data_mask;
    end

    // tx_done is registered, so it is raised on the edge that enters the
    // last clock of the final stop bit.
    always_comb begin
        done_next = 1'b0;
        case (state)
            DATA:    done_next = bit_end && last_data && !par_en_r &&
                                 (div_r == DIV_W'(1)) && !stop2_r;
            PARITY:  done_next = bit_end && (div_r == DIV_W'(1)) && !stop2_r;
            STOP:    if (bit_end)
                         done_next = stop2_r && !bit_idx[0] && (div_r == DIV_W'(1));
                     else
                         done_next = (!stop2_r || bit_idx[0]) &&
                                     (baud_cnt == div_r - DIV_W'(2));
            default: done_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (start_frame)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, start_frame})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            div_r     <= DIV_W'(1);
            dbits_r   <= 2'b11;
            par_en_r  <= 1'b0;
            stop2_r   <= 1'b0;
            par_bit_r <= 1'b0;
            shreg     <= '0;
        end else begin
            tx_done <= done_next;
            if (start_frame) begin
                state     <= START;
                tx        <= 1'b0;
                tx_busy   <= 1'b1;
                baud_cnt  <= '0;
                bit_idx   <= '0;
                div_r     <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
                dbits_r   <= cfg_data_bits;
                par_en_r  <= cfg_parity_en;
                stop2_r   <= cfg_stop2;
                par_bit_r <= (^head_m) ^ cfg_parity_odd;
                shreg     <= head_m;
            end else begin
                case (state)
                    START: begin
                        if (bit_end) begin
                            state    <= DATA;
                            tx       <= shreg[0];
                            shreg    <= shreg >> 1;
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                        end else begin
                            baud_cnt <= baud_cnt + DIV_W'(1);
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            if (last_data) begin
                                bit_idx <= '0;
                                if (par_en_r) begin
                                    state <= PARITY;
                                    tx    <= par_bit_r;
                                end else begin
                                    state <= STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                tx      <= shreg[0];
                                shreg   <= shreg >> 1;
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + DIV_W'(1);
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state    <= STOP;
                            tx       <= 1'b1;
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                        end else begin
                            baud_cnt <= baud_cnt + DIV_W'(1);
                        end
                    end
                    STOP: begin
                        if (frame_end) begin
                            state    <= IDLE;
                            tx       <= 1'b1;
                            tx_busy  <= 1'b0;
                            baud_cnt <= '0;
                        end else if (bit_end) begin
                            bit_idx  <= 3'd1;
                            baud_cnt <= '0;
                        end else begin
                            baud_cnt <= baud_cnt + DIV_W'(1);
                        end
                    end
                    default: begin
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: expected frames are queued at push time and
// checked bit-by-bit by a line monitor as the DUT shifts them out.
module tb_uart_tx_fifo;

    localparam int DIV_W = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             wr_valid = 1'b0;
    logic [7:0]       wr_data = '0;
    logic             wr_ready;
    logic [DIV_W-1:0] cfg_div = '0;
    logic [1:0]       cfg_data_bits = 2'b11;
    logic             cfg_parity_en = 1'b0;
    logic             cfg_parity_odd = 1'b0;
    logic             cfg_stop2 = 1'b0;
    logic             tx, tx_busy, tx_done;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_full;

    uart_tx_fifo #(.CLK_FREQ(50000000), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2(cfg_stop2), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
        .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] lv;
        int          nslots;
        int          div;
    } frame_t;

    frame_t exp_q[$];
    int n_checks = 0, n_pass = 0, n_fail = 0;
    int frames_done = 0, done_seen = 0, busy_cycles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line levels per bit slot: start, N data LSB first, optional parity, stop(s).
    function automatic frame_t mk_frame(input logic [7:0] b, input int div, input logic [1:0] db,
                                        input bit pe, input bit odd, input bit s2);
        frame_t f;
        int n = 5 + int'(db);
        int k = 1;
        logic p = odd;
        f.lv = '1;
        f.lv[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
            f.lv[k] = b[i];
            p = p ^ b[i];
            k++;
        end
        if (pe) begin
            f.lv[k] = p;
            k++;
        end
        k += s2 ? 2 : 1;
        f.nslots = k;
        f.div = (div == 0) ? 1 : div;
        return f;
    endfunction

    task automatic set_cfg(input int div, input logic [1:0] db, input bit pe, input bit odd, input bit s2);
        cfg_div = DIV_W'(div);
        cfg_data_bits = db;
        cfg_parity_en = pe;
        cfg_parity_odd = odd;
        cfg_stop2 = s2;
    endtask

    // exp_div is the divisor the frame will latch when it starts
    task automatic push_byte(input logic [7:0] b, input bit accepted, input int exp_div);
        wr_valid = 1'b1;
        wr_data = b;
        if (accepted)
            exp_q.push_back(mk_frame(b, exp_div, cfg_data_bits, cfg_parity_en, cfg_parity_odd, cfg_stop2));
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int c = 0;
        while (frames_done < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("frame_timeout", frames_done, target);
    endtask

    // Line monitor: a falling tx while idle starts the next expected frame.
    int     pos = 0;
    bit     active = 0;
    frame_t cur;
    always @(negedge clk) begin
        if (!resetn) begin
            active = 0;
        end else begin
            if (tx_busy) busy_cycles++;
            if (tx_done) done_seen++;
            if (!active && tx === 1'b0) begin
                if (exp_q.size() == 0) check("unexpected_frame", exp_q.size(), 1);
                else begin
                    cur = exp_q.pop_front();
                    active = 1;
                    pos = 0;
                end
            end
            if (active) begin
                check("tx_bit", tx, cur.lv[pos / cur.div]);
                check("tx_done", tx_done, pos == cur.nslots * cur.div - 1);
                check("tx_busy", tx_busy, 1);
                pos++;
                if (pos == cur.nslots * cur.div) begin
                    active = 0;
                    frames_done++;
                end
            end else begin
                check("idle_tx_done", tx_done, 0);
                check("idle_busy", tx_busy, 0);
            end
        end
    end

    int b0, d0;

    initial begin
        #12;
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_count", fifo_count, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_wr_ready", wr_ready, 1);
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 8N1, div 4
        set_cfg(4, 2'b11, 0, 0, 0);
        push_byte(8'hA5, 1, 4);
        wait_frames(1, 100);
        #1;
        check("t1_busy_fall", tx_busy, 0);
        check("t1_done_count", done_seen, 1);

        // 7 data bits, even then odd parity, div 3
        set_cfg(3, 2'b10, 1, 0, 0);
        push_byte(8'h35, 1, 3);
        wait_frames(2, 100);
        #1;
        set_cfg(3, 2'b10, 1, 1, 0);
        push_byte(8'h35, 1, 3);
        wait_frames(3, 100);
        #1;

        // 5 data bits, two stop bits, div 2; upper bits ignored
        set_cfg(2, 2'b00, 0, 0, 1);
        push_byte(8'hFF, 1, 2);
        wait_frames(4, 100);
        #1;
        push_byte(8'hE0, 1, 2);
        wait_frames(5, 100);
        #1;
        // div 0 behaves as div 1
        set_cfg(0, 2'b11, 1, 1, 1);
        push_byte(8'h5A, 1, 1);
        wait_frames(6, 100);
        #1;

        // fill to full with div 10; first byte drains immediately into the shifter
        set_cfg(10, 2'b11, 0, 0, 0);
        b0 = busy_cycles;
        d0 = done_seen;
        for (int i = 0; i < DEPTH + 1; i++)
            push_byte(8'($urandom_range(0, 255)), 1, 10);
        check("fill_count", fifo_count, DEPTH);
        check("fill_full", fifo_full, 1);
        check("fill_wr_ready", wr_ready, 0);
        push_byte(8'h77, 0, 10);
        check("full_push_ignored", fifo_count, DEPTH);
        wait_frames(6 + DEPTH + 1, 1200);
        #1;
        check("b2b_busy_cycles", busy_cycles - b0, (DEPTH + 1) * 100);
        check("b2b_done_pulses", done_seen - d0, DEPTH + 1);

        // cfg change mid-frame only affects the following frame
        set_cfg(4, 2'b11, 0, 0, 0);
        push_byte(8'h3C, 1, 4);
        push_byte(8'hC3, 1, 8);
        repeat (10) @(posedge clk);
        #1 cfg_div = DIV_W'(8);
        wait_frames(6 + DEPTH + 1 + 2, 300);
        #1;

        // reset during DATA of frame 2 with 3 bytes still queued
        set_cfg(4, 2'b11, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            push_byte(8'(8'h10 + i), 1, 4);
        wait_frames(6 + DEPTH + 1 + 3, 100);
        repeat (12) @(posedge clk);
        #2;
        check("pre_reset_count", fifo_count, 3);
        check("pre_reset_busy", tx_busy, 1);
        resetn = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_count", fifo_count, 0);
        check("abort_empty", fifo_empty, 1);
        check("abort_wr_ready", wr_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("post_reset_no_frames", frames_done, 6 + DEPTH + 1 + 3);
        check("post_reset_tx", tx, 1);
        check("post_reset_count", fifo_count, 0);
        push_byte(8'h81, 1, 4);
        wait_frames(6 + DEPTH + 1 + 4, 100);
        #1;
        check("final_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
